pipe_ctrl: RTL and testbench

//  Pipeline sequencer between the ex stage, the fetch bus and pc_reg/if_id/id_ex.

---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns ex-stage redirects and hold requests into PC redirect,
// per-stage hold and flush controls, deferring redirects while the fetch port is busy.
module pipe_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_ex_i,
   input  logic              hold_bus_i,
   output logic              jump_en_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              hold_pc_o,
   output logic              hold_if_id_o,
   output logic              hold_id_ex_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              hold_timeout_o
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam int HC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [HC_W-1:0] HCNT_SAT   = HC_W'(TIMEOUT);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pend_addr;
   logic [FC_W-1:0]   fcnt;
   logic [HC_W-1:0]   hcnt;
   logic              hold_any;

   assign hold_any = hold_ex_i | hold_bus_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= RUN;
         pend_addr      <= '0;
         fcnt           <= '0;
         hcnt           <= '0;
         hold_timeout_o <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!hold_ex_i && jump_en_i) begin
                  if (hold_bus_i) begin
                     pend_addr <= jump_addr_i;
                     state     <= PEND;
                  end else if (FLUSH_CYCLES > 1) begin
                     fcnt  <= FLUSH_LOAD;
                     state <= FLUSH;
                  end
               end
            end
            PEND: begin
               if (!hold_bus_i) begin
                  if (FLUSH_CYCLES > 1) begin
                     fcnt  <= FLUSH_LOAD;
                     state <= FLUSH;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            FLUSH: begin
               if (fcnt <= FC_W'(1)) begin
                  fcnt  <= '0;
                  state <= RUN;
               end else begin
                  fcnt <= fcnt - FC_W'(1);
               end
            end
            default: state <= RUN;
         endcase

         // Watchdog: the flag sets on the same edge the counter reaches TIMEOUT.
         if (!hold_any) begin
            hcnt <= '0;
         end else if (hcnt != HCNT_SAT) begin
            hcnt <= hcnt + HC_W'(1);
         end
         if (TIMEOUT != 0 && hold_any && (32'(hcnt) + 32'd1 >= 32'(TIMEOUT))) begin
            hold_timeout_o <= 1'b1;
         end
      end
   end

   // Outputs are forced low while reset is asserted, whatever the inputs say.
   always_comb begin
      jump_en_o     = 1'b0;
      jump_addr_o   = '0;
      hold_pc_o     = 1'b0;
      hold_if_id_o  = 1'b0;
      hold_id_ex_o  = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               if (hold_ex_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end else if (jump_en_i) begin
                  flush_if_id_o = 1'b1;
                  flush_id_ex_o = 1'b1;
                  if (hold_bus_i) begin
                     hold_pc_o = 1'b1;
                  end else begin
                     jump_en_o   = 1'b1;
                     jump_addr_o = jump_addr_i;
                  end
               end else if (hold_bus_i) begin
                  hold_pc_o     = 1'b1;
                  hold_if_id_o  = 1'b1;
                  flush_id_ex_o = 1'b1;
               end
            end
            PEND: begin
               flush_if_id_o = 1'b1;
               flush_id_ex_o = 1'b1;
               if (hold_bus_i) begin
                  hold_pc_o = 1'b1;
               end else begin
                  jump_en_o   = 1'b1;
                  jump_addr_o = pend_addr;
               end
            end
            FLUSH: begin
               flush_if_id_o = 1'b1;
               flush_id_ex_o = 1'b1;
            end
            default: begin
               jump_en_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected output vectors are queued as each step is
// driven and popped when the outputs are sampled on the falling edge.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_ex_i;
   logic        hold_bus_i;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        hold_pc_o;
   logic        hold_if_id_o;
   logic        hold_id_ex_o;
   logic        flush_if_id_o;
   logic        flush_id_ex_o;
   logic        hold_timeout_o;

   typedef struct packed {
      logic        jen;
      logic [31:0] addr;
      logic        hpc;
      logic        hif;
      logic        hid;
      logic        fif;
      logic        fid;
      logic        to;
   } out_t;

   out_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   logic expTo = 1'b0;

   pipe_ctrl #(
      .ADDR_W      (32),
      .FLUSH_CYCLES(2),
      .TIMEOUT     (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .hold_ex_i     (hold_ex_i),
      .hold_bus_i    (hold_bus_i),
      .jump_en_o     (jump_en_o),
      .jump_addr_o   (jump_addr_o),
      .hold_pc_o     (hold_pc_o),
      .hold_if_id_o  (hold_if_id_o),
      .hold_id_ex_o  (hold_id_ex_o),
      .flush_if_id_o (flush_if_id_o),
      .flush_id_ex_o (flush_id_ex_o),
      .hold_timeout_o(hold_timeout_o)
   );

   always #5 clk = ~clk;

   // hf packs {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
   function automatic out_t mk(input logic jen, input logic [31:0] a,
                               input logic [4:0] hf, input logic to);
      out_t o;
      o.jen  = jen;
      o.addr = a;
      o.hpc  = hf[4];
      o.hif  = hf[3];
      o.hid  = hf[2];
      o.fif  = hf[1];
      o.fid  = hf[0];
      o.to   = to;
      return o;
   endfunction

   task automatic checkOutput(input string tag);
      out_t obs;
      out_t exp;
      obs = {jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
             flush_if_id_o, flush_id_ex_o, hold_timeout_o};
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $display("[TB] FAIL %s scoreboard empty, observed=%h", tag, obs);
      end else begin
         exp = expQ.pop_front();
         assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
      end
   endtask

   task automatic applyStimulus(input string tag, input logic jen, input logic [31:0] a,
                                input logic hex, input logic hbus, input out_t exp);
      jump_en_i   = jen;
      jump_addr_i = a;
      hold_ex_i   = hex;
      hold_bus_i  = hbus;
      expQ.push_back(exp);
      @(negedge clk);
      checkOutput(tag);
      @(posedge clk);
      #1;
   endtask

   localparam logic [4:0] NONE   = 5'b00000;
   localparam logic [4:0] FLUSH2 = 5'b00011;
   localparam logic [4:0] PENDHF = 5'b10011;
   localparam logic [4:0] HOLDEX = 5'b11100;
   localparam logic [4:0] BUBBLE = 5'b11001;

   initial begin
      rst         = 1'b0;
      jump_en_i   = 1'b0;
      jump_addr_i = '0;
      hold_ex_i   = 1'b1;
      hold_bus_i  = 1'b0;
      #3;
      expQ.push_back(mk(1'b0, 32'h0, NONE, 1'b0));
      checkOutput("reset_gated");
      hold_ex_i = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: idle after reset
      applyStimulus("idle0", 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b0));
      applyStimulus("idle1", 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b0));

      // 2: immediate redirect, second flush cycle ignores a new jump request
      applyStimulus("jmp_n",   1'b1, 32'h100, 1'b0, 1'b0, mk(1'b1, 32'h100, FLUSH2, 1'b0));
      applyStimulus("jmp_n1",  1'b1, 32'h999, 1'b0, 1'b0, mk(1'b0, 32'h0, FLUSH2, 1'b0));
      applyStimulus("jmp_n2",  1'b0, 32'h0,   1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b0));

      // 3: redirect deferred by a busy fetch port
      for (int i = 0; i < 3; i++)
         applyStimulus("pend_hold", 1'b1, 32'h2000, 1'b0, 1'b1, mk(1'b0, 32'h0, PENDHF, 1'b0));
      applyStimulus("pend_go",  1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 32'h2000, FLUSH2, 1'b0));
      applyStimulus("pend_fl",  1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, FLUSH2, 1'b0));
      applyStimulus("pend_end", 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b0));

      // 4: ex hold wins over a pending jump request
      for (int i = 0; i < 4; i++)
         applyStimulus("ex_hold", 1'b1, 32'h40, 1'b1, 1'b0, mk(1'b0, 32'h0, HOLDEX, 1'b0));
      applyStimulus("ex_go",   1'b1, 32'h40, 1'b0, 1'b0, mk(1'b1, 32'h40, FLUSH2, 1'b0));
      applyStimulus("ex_fl",   1'b0, 32'h0,  1'b0, 1'b0, mk(1'b0, 32'h0, FLUSH2, 1'b0));
      applyStimulus("ex_end",  1'b0, 32'h0,  1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b0));

      // 5: bus bubble for 10 cycles trips the watchdog after the 8th edge
      for (int i = 1; i <= 10; i++) begin
         expTo = (i >= 9);
         applyStimulus("wdog_bubble", 1'b0, 32'h0, 1'b0, 1'b1, mk(1'b0, 32'h0, BUBBLE, expTo));
      end
      applyStimulus("wdog_sticky0", 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b1));
      applyStimulus("wdog_sticky1", 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b1));

      // 6: asynchronous reset while a redirect is pending
      applyStimulus("rst_enter", 1'b1, 32'h3000, 1'b0, 1'b1, mk(1'b0, 32'h0, PENDHF, 1'b1));
      jump_en_i = 1'b0;
      #1;
      expQ.push_back(mk(1'b0, 32'h0, PENDHF, 1'b1));
      checkOutput("rst_in_pend");
      #1;
      rst = 1'b0;
      #1;
      expQ.push_back(mk(1'b0, 32'h0, NONE, 1'b0));
      checkOutput("rst_async");
      hold_bus_i = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus("rst_after0", 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b0));
      applyStimulus("rst_after1", 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 32'h0, NONE, 1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
